// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory line arbiter between the I-cache and D-cache.
package pmem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_I, ARB_D} arb_state_t;
  typedef enum logic {ARB_OWNER_I, ARB_OWNER_D} arb_owner_t;

  // Pending request vector, one bit per cache
  typedef struct packed {
    logic d;
    logic i;
  } arb_req_t;

  function automatic arb_state_t owner_state(arb_owner_t o);
    return (o == ARB_OWNER_D) ? ARB_D : ARB_I;
  endfunction

endpackage

// File: rtl/pmem_arb_picker.sv
// Combinational grant choice for the arbiter; PMEM_ARB_ROUND_ROBIN_EN selects
// round-robin on conflicts, otherwise the D-cache always wins.
module pmem_arb_picker
  import pmem_arbiter_pkg::*;
(
  input  arb_req_t   req,
  input  arb_owner_t last_grant,
  output logic       grant_vld,
  output arb_owner_t grant
);

  always_comb begin
    grant_vld = req.i | req.d;
    grant     = ARB_OWNER_I;
    if (req.d && !req.i) begin
      grant = ARB_OWNER_D;
    end else if (req.d && req.i) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      grant = (last_grant == ARB_OWNER_I) ? ARB_OWNER_D : ARB_OWNER_I;
`else
      // Fixed priority: the D bit is forced, history has no effect
      grant = arb_owner_t'(last_grant | ARB_OWNER_D);
`endif
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the physical memory line port between I-cache and D-cache, one
// registered request at a time. Conflict policy set by PMEM_ARB_ROUND_ROBIN_EN.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state, state_nxt;
  arb_owner_t        last_grant;
  arb_owner_t        grant;
  logic              grant_vld;
  logic              take;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_wr;
  arb_req_t          req;

  assign req = '{d: d_read | d_write, i: i_read};

  pmem_arb_picker u_picker (
    .req        (req),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  assign take = (state == ARB_IDLE) && grant_vld;

  always_comb begin
    state_nxt = state;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state)
      ARB_IDLE: if (grant_vld) state_nxt = owner_state(grant);
      ARB_I: if (mem_resp) begin
        i_resp    = 1'b1;
        state_nxt = ARB_IDLE;
      end
      ARB_D: if (mem_resp) begin
        d_resp    = 1'b1;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_OWNER_I;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wr     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (i_resp) last_grant <= ARB_OWNER_I;
      if (d_resp) last_grant <= ARB_OWNER_D;
      if (take) begin
        if (grant == ARB_OWNER_D) begin
          lat_addr <= d_address;
          // d_write wins if both D strobes are (illegally) high
          lat_wr   <= d_write;
          if (d_write) lat_wdata <= d_wdata;
        end else begin
          lat_addr <= i_address;
          lat_wr   <= 1'b0;
        end
      end
    end
  end

  // Strobes decode straight from state so reset drops them without a clock
  assign mem_read    = (state != ARB_IDLE) && !lat_wr;
  assign mem_write   = (state != ARB_IDLE) &&  lat_wr;
  assign mem_address = lat_addr;
  assign mem_wdata   = lat_wdata;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;

endmodule
